// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//   Coprocessor-0 state and exception-entry controller. It takes an
//   exception request from the detect logic and records EPC and Cause. It
//   pushes the Status KU/IE stack and redirects fetch to the exception
//   vector for one cycle. It also pops the stack on RFE and runs the
//   Count/Compare timer. The masked interrupt vector and IEc are fed back
//   to the detect logic.
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   pendingexception   : exception request (taken only in IDLE)
//   exccode            : cause code for the request
//   exc_pc, exc_bd     : faulting PC and its branch-delay-slot flag
//   hw_int             : external interrupt lines -> Cause.IP[7:2]
//   rfe                : return-from-exception this cycle
//   mtc0_we, cp0_addr,
//   cp0_wdata          : CP0 register write port
//   cp0_rdata          : combinational read of register at cp0_addr
//   iec                : Status.IEc
//   interrupts         : Cause.IP & Status.IM
//   flush              : squash pipeline (TAKE state only)
//   redirect_valid     : fetch must load redirect_pc (TAKE state only)
//   redirect_pc        : exception vector address
//   epc_out            : current EPC
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0080,
  parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic [4:0]  exccode,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [5:0]  hw_int,
  input  logic        rfe,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        iec,
  output logic [7:0]  interrupts,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  typedef enum logic {
    IDLE = 1'b0,
    TAKE = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_flush;
  logic        r_redirectValid;
  logic [31:0] r_redirectPc;

  // Status is held as its two implemented fields: IM and the KU/IE stack
  // {KUo,IEo,KUp,IEp,KUc,IEc}.
  logic [7:0]  r_statusIm;
  logic [5:0]  r_statusStk;

  logic        r_causeBd;
  logic [4:0]  r_causeExc;
  logic [1:0]  r_causeSw;

  logic [31:0] r_epc;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timerIp;

  logic        w_take;
  logic        w_rfe;
  logic        w_swWrite;
  logic        w_wrStatus;
  logic        w_wrCause;
  logic        w_wrEpc;
  logic        w_wrCount;
  logic        w_wrCompare;
  logic [31:0] w_countInc;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // Priority: exception entry beats RFE, and both beat software writes to
  // Status/Cause/EPC. Count/Compare writes are never displaced.
  assign w_take      = (r_state == IDLE) && pendingexception;
  assign w_rfe       = (r_state == IDLE) && rfe && !w_take;
  assign w_swWrite   = mtc0_we && !w_take && !w_rfe;
  assign w_wrStatus  = w_swWrite && (cp0_addr == ADDR_STATUS);
  assign w_wrCause   = w_swWrite && (cp0_addr == ADDR_CAUSE);
  assign w_wrEpc     = w_swWrite && (cp0_addr == ADDR_EPC);
  assign w_wrCount   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign w_wrCompare = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign w_countInc  = r_count + 32'd1;

  // IP[7] shares the top hardware line with the timer interrupt.
  assign w_ip     = {hw_int[5] | r_timerIp, hw_int[4:0], r_causeSw};
  assign w_status = {16'd0, r_statusIm, 2'b00, r_statusStk};
  assign w_cause  = {r_causeBd, 15'd0, w_ip, 1'b0, r_causeExc, 2'b00};

  assign iec            = r_statusStk[0];
  assign interrupts     = w_ip & r_statusIm;
  assign flush          = r_flush;
  assign redirect_valid = r_redirectValid;
  assign redirect_pc    = r_redirectPc;
  assign epc_out        = r_epc;

  // Exception FSM: one TAKE cycle per accepted request, with registered
  // flush/redirect outputs. Requests arriving during TAKE are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_flush         <= 1'b0;
      r_redirectValid <= 1'b0;
      r_redirectPc    <= EXC_VECTOR;
    end else begin
      r_redirectPc <= EXC_VECTOR;
      case (r_state)
        IDLE: begin
          if (pendingexception) begin
            r_state         <= TAKE;
            r_flush         <= 1'b1;
            r_redirectValid <= 1'b1;
          end else begin
            r_flush         <= 1'b0;
            r_redirectValid <= 1'b0;
          end
        end
        TAKE: begin
          r_state         <= IDLE;
          r_flush         <= 1'b0;
          r_redirectValid <= 1'b0;
        end
        default: begin
          r_state         <= IDLE;
          r_flush         <= 1'b0;
          r_redirectValid <= 1'b0;
        end
      endcase
    end
  end

  // Status: exception pushes the KU/IE stack with kernel mode and interrupts
  // off, RFE pops it while keeping the old pair, otherwise software may write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_statusIm  <= RESET_STATUS[15:8];
      r_statusStk <= RESET_STATUS[5:0];
    end else if (w_take) begin
      r_statusStk <= {r_statusStk[3:0], 2'b00};
    end else if (w_rfe) begin
      r_statusStk <= {r_statusStk[5:4], r_statusStk[5:2]};
    end else if (w_wrStatus) begin
      r_statusIm  <= cp0_wdata[15:8];
      r_statusStk <= cp0_wdata[5:0];
    end
  end

  // Cause and EPC: exception entry records the fault. EPC points at the
  // branch when the fault sits in a delay slot. Software can set only the
  // two soft interrupt bits of Cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_causeBd  <= 1'b0;
      r_causeExc <= 5'd0;
      r_causeSw  <= 2'b00;
      r_epc      <= 32'd0;
    end else if (w_take) begin
      r_causeBd  <= exc_bd;
      r_causeExc <= exccode;
      r_epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
    end else begin
      if (w_wrCause) begin
        r_causeSw <= cp0_wdata[9:8];
      end
      if (w_wrEpc) begin
        r_epc <= cp0_wdata;
      end
    end
  end

  // Count/Compare timer. A software load of Count replaces the increment.
  // A Compare write clears the pending timer interrupt and beats a
  // same-cycle match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_timerIp <= 1'b0;
    end else begin
      r_count <= w_wrCount ? cp0_wdata : w_countInc;
      if (w_wrCompare) begin
        r_compare <= cp0_wdata;
        r_timerIp <= 1'b0;
      end else if (w_countInc == r_compare) begin
        r_timerIp <= 1'b1;
      end
    end
  end

  // Read port shows pre-edge register contents; unimplemented addresses read 0.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = r_count;
      ADDR_COMPARE: cp0_rdata = r_compare;
      ADDR_STATUS:  cp0_rdata = w_status;
      ADDR_CAUSE:   cp0_rdata = w_cause;
      ADDR_EPC:     cp0_rdata = r_epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//   Self-checking bench for cp0_exc_ctrl. It uses a table of single-cycle
//   vectors with hand-computed expectations. Hand-written sequences cover
//   the timer, reset in the middle of TAKE, and a request that is held
//   through TAKE.
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  localparam logic [31:0] EXC_VEC = 32'h8000_0080;

  logic        clk;
  logic        reset;
  logic        pendingexception;
  logic [4:0]  exccode;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [5:0]  hw_int;
  logic        rfe;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        iec;
  logic [7:0]  interrupts;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc_out;

  int total;
  int bad;

  typedef struct {
    logic        pend;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  hw;
    logic        rfe;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  chkAddr;
    logic [31:0] expRdata;
    logic        expFlush;
    logic        expIec;
    logic [7:0]  expInt;
  } vec_t;

  vec_t vecs[$];

  cp0_exc_ctrl #(
    .EXC_VECTOR  (EXC_VEC),
    .RESET_STATUS(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pendingexception(pendingexception),
    .exccode         (exccode),
    .exc_pc          (exc_pc),
    .exc_bd          (exc_bd),
    .hw_int          (hw_int),
    .rfe             (rfe),
    .mtc0_we         (mtc0_we),
    .cp0_addr        (cp0_addr),
    .cp0_wdata       (cp0_wdata),
    .cp0_rdata       (cp0_rdata),
    .iec             (iec),
    .interrupts      (interrupts),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .epc_out         (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pend, input logic [4:0] code, input logic [31:0] pc,
                              input logic bd, input logic [5:0] hw, input logic r,
                              input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [4:0] chk, input logic [31:0] expR,
                              input logic expF, input logic expI, input logic [7:0] expInt);
    vec_t v;
    v.pend = pend; v.code = code; v.pc = pc; v.bd = bd; v.hw = hw; v.rfe = r;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chkAddr = chk; v.expRdata = expR;
    v.expFlush = expF; v.expIec = expI; v.expInt = expInt;
    return v;
  endfunction

  // Drives one vector for a single clock, then returns the strobes to idle
  // and points the read port at the register under check.
  task automatic applyStimulus(input vec_t v);
    pendingexception = v.pend;
    exccode          = v.code;
    exc_pc           = v.pc;
    exc_bd           = v.bd;
    hw_int           = v.hw;
    rfe              = v.rfe;
    mtc0_we          = v.we;
    cp0_addr         = v.addr;
    cp0_wdata        = v.wdata;
    @(posedge clk);
    #1;
    pendingexception = 1'b0;
    rfe              = 1'b0;
    mtc0_we          = 1'b0;
    cp0_addr         = v.chkAddr;
    #1;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    mtc0_we   = 1'b1;
    cp0_addr  = addr;
    cp0_wdata = data;
    @(posedge clk);
    #1;
    mtc0_we = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    checkOutput(name, cp0_rdata, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    pendingexception = 1'b0;
    exccode = 5'd0;
    exc_pc = 32'd0;
    exc_bd = 1'b0;
    hw_int = 6'd0;
    rfe = 1'b0;
    mtc0_we = 1'b0;
    cp0_addr = 5'd0;
    cp0_wdata = 32'd0;

    //   pend code pc             bd hw        rfe we addr  wdata         chk  expRdata      fl iec int
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd12, 32'h0000_FF01, 5'd12, 32'h0000_FF01, 0, 1, 8'h00));
    vecs.push_back(mk(1, 5'd8,  32'h0040_0010, 0, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd14, 32'h0040_0010, 1, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd13, 32'h0000_0020, 0, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd12, 32'h0000_FF04, 0, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 1, 0, 5'd0,  32'h0,         5'd12, 32'h0000_FF01, 0, 1, 8'h00));
    vecs.push_back(mk(1, 5'd4,  32'h0040_0024, 1, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd14, 32'h0040_0020, 1, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd13, 32'h8000_0010, 0, 0, 8'h00));
    vecs.push_back(mk(1, 5'd12, 32'h0040_0100, 0, 6'b000000, 1, 1, 5'd14, 32'hDEAD_BEEF, 5'd14, 32'h0040_0100, 1, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 0, 5'd0,  32'h0,         5'd12, 32'h0000_FF10, 0, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 1, 0, 5'd0,  32'h0,         5'd12, 32'h0000_FF14, 0, 0, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd12, 32'h0000_0101, 5'd12, 32'h0000_0101, 0, 1, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd13, 32'h0000_0300, 5'd13, 32'h0000_0330, 0, 1, 8'h01));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0330, 0, 1, 8'h01));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0030, 0, 1, 8'h00));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000011, 0, 1, 5'd12, 32'h0000_FF00, 5'd13, 32'h0000_0C30, 0, 0, 8'h0C));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b100000, 0, 1, 5'd5,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 0, 0, 8'h80));
    vecs.push_back(mk(0, 5'd0,  32'h0,         0, 6'b000000, 0, 1, 5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000, 0, 0, 8'h00));

    // Reset state
    #12;
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_rv", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_rpc", redirect_pc, EXC_VEC);
    readCheck("rst_status", 5'd12, 32'h0);
    readCheck("rst_cause", 5'd13, 32'h0);
    readCheck("rst_epc", 5'd14, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_rdata", i), cp0_rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].expFlush});
      checkOutput($sformatf("v%0d_rv", i), {31'd0, redirect_valid}, {31'd0, vecs[i].expFlush});
      checkOutput($sformatf("v%0d_iec", i), {31'd0, iec}, {31'd0, vecs[i].expIec});
      checkOutput($sformatf("v%0d_int", i), {24'd0, interrupts}, {24'd0, vecs[i].expInt});
      if (vecs[i].expFlush) begin
        checkOutput($sformatf("v%0d_rpc", i), redirect_pc, EXC_VEC);
      end
      if (vecs[i].chkAddr == 5'd14) begin
        checkOutput($sformatf("v%0d_epcout", i), epc_out, vecs[i].expRdata);
      end
    end
    hw_int = 6'd0;

    // Timer: Compare=5, Count=0, IM7 enabled
    writeReg(5'd12, 32'h0000_8000);
    writeReg(5'd11, 32'd5);
    writeReg(5'd9, 32'd0);
    readCheck("tmr_count0", 5'd9, 32'd0);
    tick(4);
    readCheck("tmr_count4", 5'd9, 32'd4);
    checkOutput("tmr_int_pre", {24'd0, interrupts}, 32'h0);
    tick(1);
    readCheck("tmr_count5", 5'd9, 32'd5);
    readCheck("tmr_cause", 5'd13, 32'h0000_8030);
    checkOutput("tmr_int_set", {24'd0, interrupts}, 32'h80);
    tick(2);
    checkOutput("tmr_int_hold", {24'd0, interrupts}, 32'h80);
    writeReg(5'd11, 32'h0000_0100);
    checkOutput("tmr_int_clr", {24'd0, interrupts}, 32'h0);
    readCheck("tmr_cause_clr", 5'd13, 32'h0000_0030);
    writeReg(5'd9, 32'hFFFF_FFFF);
    readCheck("tmr_count_max", 5'd9, 32'hFFFF_FFFF);
    tick(1);
    readCheck("tmr_count_wrap", 5'd9, 32'h0);

    // Reset asserted during TAKE aborts the redirect at once
    exccode = 5'd2;
    exc_pc = 32'h0040_0200;
    exc_bd = 1'b0;
    pendingexception = 1'b1;
    @(posedge clk);
    #1;
    pendingexception = 1'b0;
    checkOutput("take_flush", {31'd0, flush}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_flush", {31'd0, flush}, 32'd0);
    checkOutput("rstmid_rv", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rstmid_rpc", redirect_pc, EXC_VEC);
    readCheck("rstmid_status", 5'd12, 32'h0);
    readCheck("rstmid_cause", 5'd13, 32'h0);
    readCheck("rstmid_epc", 5'd14, 32'h0);
    readCheck("rstmid_count", 5'd9, 32'h0);
    readCheck("rstmid_compare", 5'd11, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // A request held through TAKE is not taken a second time
    exccode = 5'd3;
    exc_pc = 32'h0040_0300;
    pendingexception = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dbl_flush1", {31'd0, flush}, 32'd1);
    exccode = 5'd5;
    exc_pc = 32'h0040_0400;
    @(posedge clk);
    #1;
    pendingexception = 1'b0;
    checkOutput("dbl_flush2", {31'd0, flush}, 32'd0);
    checkOutput("dbl_rv2", {31'd0, redirect_valid}, 32'd0);
    readCheck("dbl_epc", 5'd14, 32'h0040_0300);
    readCheck("dbl_cause", 5'd13, 32'h0000_000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
